// File: rtl/e203_exu_muldiv_seq_pkg.sv
// Shared constants for the sequential mul/div controller:
// funct3 op codes, FSM state codes and iteration counts.
package e203_exu_muldiv_seq_pkg;

   localparam logic [2:0] E203_MULDIV_OP_MUL    = 3'd0;
   localparam logic [2:0] E203_MULDIV_OP_MULH   = 3'd1;
   localparam logic [2:0] E203_MULDIV_OP_MULHSU = 3'd2;
   localparam logic [2:0] E203_MULDIV_OP_MULHU  = 3'd3;
   localparam logic [2:0] E203_MULDIV_OP_DIV    = 3'd4;
   localparam logic [2:0] E203_MULDIV_OP_DIVU   = 3'd5;
   localparam logic [2:0] E203_MULDIV_OP_REM    = 3'd6;
   localparam logic [2:0] E203_MULDIV_OP_REMU   = 3'd7;

   localparam logic [2:0] E203_MULDIV_ST_IDLE   = 3'd0;
   localparam logic [2:0] E203_MULDIV_ST_EXEC   = 3'd1;
   localparam logic [2:0] E203_MULDIV_ST_CORR_Q = 3'd2;
   localparam logic [2:0] E203_MULDIV_ST_CORR_R = 3'd3;
   localparam logic [2:0] E203_MULDIV_ST_DONE   = 3'd4;

   localparam int E203_MULDIV_MUL_STEPS = 17;
   localparam int E203_MULDIV_DIV_STEPS = 33;
   localparam int E203_MULDIV_CNT_W     = 6;

endpackage

// File: rtl/e203_exu_muldiv_seq_if.sv
// Issue/result handshake and datapath control bundle.
// slave: controller side; master: issuing pipeline + datapath.
interface e203_exu_muldiv_seq_if;
   import e203_exu_muldiv_seq_pkg::*;

   logic       i_valid;
   logic       i_ready;
   logic [2:0] i_op;
   logic       i_b2b;
   logic       i_div0;
   logic       i_ovf;
   logic       i_flush;
   logic       o_valid;
   logic       o_ready;
   logic       o_special;
   logic       dp_init;
   logic       dp_step;
   logic       dp_corr_q;
   logic       dp_corr_r;
   logic       dp_b2b_sel;
   logic       dp_is_div;
   logic [E203_MULDIV_CNT_W-1:0] dp_cnt;

   modport slave (
      input  i_valid, i_op, i_b2b, i_div0, i_ovf,
      input  i_flush, o_ready,
      output i_ready, o_valid, o_special,
      output dp_init, dp_step, dp_corr_q, dp_corr_r,
      output dp_b2b_sel, dp_is_div, dp_cnt
   );

   modport master (
      output i_valid, i_op, i_b2b, i_div0, i_ovf,
      output i_flush, o_ready,
      input  i_ready, o_valid, o_special,
      input  dp_init, dp_step, dp_corr_q, dp_corr_r,
      input  dp_b2b_sel, dp_is_div, dp_cnt
   );

endinterface

// File: rtl/e203_exu_muldiv_seq.sv
// Sequencer for the multi-cycle mul/div unit: FSM + step counter.
// Ports: clk, rst_n (async low), bus (slave: issue/result/dp ctrl).
module e203_exu_muldiv_seq
   import e203_exu_muldiv_seq_pkg::*;
#(
   parameter int MUL_STEPS = E203_MULDIV_MUL_STEPS,
   parameter int DIV_STEPS = E203_MULDIV_DIV_STEPS
) (
   input logic                 clk,
   input logic                 rst_n,
   e203_exu_muldiv_seq_if.slave bus
);

   localparam int CW = E203_MULDIV_CNT_W;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_STEPS - 1);

   logic [2:0]    state_q;
   logic [2:0]    state_d;
   logic [CW-1:0] cnt_q;
   logic [2:0]    op_q;
   logic          special_q;
   logic          b2b_q;

   logic st_idle, st_exec, st_cq, st_cr, st_done;
   logic accept, is_div, last, clr;
   logic acc_div, acc_special, acc_b2b;

   assign st_idle = (state_q == E203_MULDIV_ST_IDLE);
   assign st_exec = (state_q == E203_MULDIV_ST_EXEC);
   assign st_cq   = (state_q == E203_MULDIV_ST_CORR_Q);
   assign st_cr   = (state_q == E203_MULDIV_ST_CORR_R);
   assign st_done = (state_q == E203_MULDIV_ST_DONE);

   // rst_n gating keeps the issue side quiet while reset is held
   assign bus.i_ready = rst_n & st_idle & ~bus.i_flush;
   assign accept      = bus.i_ready & bus.i_valid;

   assign acc_div     = bus.i_op[2];
   assign acc_special = acc_div & (bus.i_div0 | bus.i_ovf);
   assign acc_b2b     = (bus.i_op == E203_MULDIV_OP_MUL) & bus.i_b2b;

   assign is_div = (op_q >= E203_MULDIV_OP_DIV);
   assign last   = is_div ? (cnt_q == DIV_LAST)
                          : (cnt_q == MUL_LAST);

   // special/b2b flags live until the result leaves DONE or is aborted
   assign clr = bus.i_flush | (st_done & bus.o_ready);

   always_comb begin
      state_d = state_q;
      if (bus.i_flush) begin
         state_d = E203_MULDIV_ST_IDLE;
      end else begin
         unique case (1'b1)
            st_idle: if (accept)
               state_d = (acc_special | acc_b2b)
                       ? E203_MULDIV_ST_DONE
                       : E203_MULDIV_ST_EXEC;
            st_exec: if (last)
               state_d = is_div ? E203_MULDIV_ST_CORR_Q
                                : E203_MULDIV_ST_DONE;
            st_cq:   state_d = E203_MULDIV_ST_CORR_R;
            st_cr:   state_d = E203_MULDIV_ST_DONE;
            st_done: if (bus.o_ready)
               state_d = E203_MULDIV_ST_IDLE;
            default: state_d = E203_MULDIV_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= E203_MULDIV_ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         special_q <= 1'b0;
         b2b_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q      <= bus.i_op;
            cnt_q     <= '0;
            special_q <= acc_special;
            b2b_q     <= acc_b2b;
         end else begin
            if (bus.dp_step)
               cnt_q <= cnt_q + 1'b1;
            if (clr) begin
               special_q <= 1'b0;
               b2b_q     <= 1'b0;
            end
         end
      end
   end

   assign bus.dp_init    = accept;
   assign bus.dp_step    = st_exec & ~bus.i_flush;
   assign bus.dp_corr_q  = st_cq & ~bus.i_flush;
   assign bus.dp_corr_r  = st_cr & ~bus.i_flush;
   assign bus.o_valid    = st_done & ~bus.i_flush;
   assign bus.o_special  = special_q;
   assign bus.dp_b2b_sel = b2b_q;
   assign bus.dp_is_div  = is_div;
   assign bus.dp_cnt     = cnt_q;

endmodule

// File: tb/tb_e203_exu_muldiv_seq.sv
// Directed bench for the mul/div sequencer.
// Cycle 0 is the accept cycle; checks sample 3 ns after each edge.
module tb_e203_exu_muldiv_seq;
   import e203_exu_muldiv_seq_pkg::*;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   e203_exu_muldiv_seq_if bus();

   e203_exu_muldiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [2:0] op,
                         input logic b2b, input logic d0,
                         input logic ov, input logic fl,
                         input logic ordy);
      bus.i_valid = v;
      bus.i_op    = op;
      bus.i_b2b   = b2b;
      bus.i_div0  = d0;
      bus.i_ovf   = ov;
      bus.i_flush = fl;
      bus.o_ready = ordy;
   endtask

   // {i_ready, dp_init, dp_step, dp_corr_q, dp_corr_r, o_valid}
   function automatic logic [5:0] obs();
      return {bus.i_ready, bus.dp_init, bus.dp_step,
              bus.dp_corr_q, bus.dp_corr_r, bus.o_valid};
   endfunction

   task automatic test_reset();
      checks++;
      if ({obs(), bus.dp_cnt, bus.o_special,
           bus.dp_b2b_sel, bus.dp_is_div} !== 15'd0) begin
         errs++;
         $display("FAIL reset_outs got=%b %0d exp all zero",
                  obs(), bus.dp_cnt);
      end
      tick();
      rst_n = 1'b1;
      #2;
      checks++;
      if (obs() !== 6'b100000) begin
         errs++;
         $display("FAIL reset_release got=%b exp=100000", obs());
      end
      tick();
   endtask

   // Full-length op; expected timeline derived from op class.
   task automatic test_iterative(input logic [2:0] op,
                                 input logic b2b,
                                 input logic d0);
      int steps;
      int done;
      logic dv;
      logic [5:0] exp;
      dv    = op[2];
      steps = dv ? 33 : 17;
      done  = dv ? 36 : 18;
      set_in(1'b1, op, b2b, d0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c <= done + 1; c++) begin
         if (c == 1) bus.i_valid = 1'b0;
         #2;
         exp = {c == 0 || c == done + 1, c == 0,
                c >= 1 && c <= steps,
                dv && c == steps + 1,
                dv && c == steps + 2,
                c == done};
         checks++;
         if (obs() !== exp) begin
            errs++;
            $display("FAIL seq op=%0d c=%0d got=%b exp=%b",
                     op, c, obs(), exp);
         end
         if (c >= 1 && c <= steps) begin
            checks++;
            if (bus.dp_cnt !== 6'(c - 1)) begin
               errs++;
               $display("FAIL cnt op=%0d c=%0d got=%0d exp=%0d",
                        op, c, bus.dp_cnt, c - 1);
            end
         end
         if (c == 1) begin
            checks++;
            if (bus.dp_is_div !== dv) begin
               errs++;
               $display("FAIL is_div op=%0d got=%b exp=%b",
                        op, bus.dp_is_div, dv);
            end
         end
         if (c == done) begin
            checks++;
            if ({bus.o_special, bus.dp_b2b_sel} !== 2'b00) begin
               errs++;
               $display("FAIL flags op=%0d got=%b%b exp=00",
                        op, bus.o_special, bus.dp_b2b_sel);
            end
         end
         tick();
      end
   endtask

   // Single-cycle result (div special case or fused MUL).
   task automatic test_short(input logic [2:0] op,
                             input logic b2b, input logic d0,
                             input logic ov, input logic spc);
      set_in(1'b1, op, b2b, d0, ov, 1'b0, 1'b1);
      #2;
      checks++;
      if (obs() !== 6'b110000) begin
         errs++;
         $display("FAIL short_acc op=%0d got=%b exp=110000",
                  op, obs());
      end
      tick();
      bus.i_valid = 1'b0;
      #2;
      checks++;
      if ({obs(), bus.o_special, bus.dp_b2b_sel} !=
          {6'b000001, spc, ~spc}) begin
         errs++;
         $display("FAIL short_done op=%0d got=%b%b%b exp=%b%b%b",
                  op, obs(), bus.o_special, bus.dp_b2b_sel,
                  6'b000001, spc, ~spc);
      end
      tick();
      #2;
      checks++;
      if ({obs(), bus.o_special, bus.dp_b2b_sel} !== 8'b10000000)
      begin
         errs++;
         $display("FAIL short_idle op=%0d got=%b%b%b exp=10000000",
                  op, obs(), bus.o_special, bus.dp_b2b_sel);
      end
      tick();
   endtask

   task automatic test_flush();
      set_in(1'b1, E203_MULDIV_OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      repeat (10) tick();
      bus.i_flush = 1'b1;
      #2;
      checks++;
      if ({obs(), bus.dp_cnt} !== {6'b000000, 6'd10}) begin
         errs++;
         $display("FAIL flush_exec got=%b cnt=%0d exp=000000 cnt=10",
                  obs(), bus.dp_cnt);
      end
      tick();
      bus.i_flush = 1'b0;
      #2;
      checks++;
      if (obs() !== 6'b100000) begin
         errs++;
         $display("FAIL flush_idle got=%b exp=100000", obs());
      end
      tick();
      // flush wins over the result handshake in DONE
      set_in(1'b1, E203_MULDIV_OP_DIV, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b1;
      #2;
      checks++;
      if ({obs(), bus.o_special} !== 7'b0000001) begin
         errs++;
         $display("FAIL flush_done got=%b%b exp=0000001",
                  obs(), bus.o_special);
      end
      tick();
      bus.i_flush = 1'b0;
      #2;
      checks++;
      if ({obs(), bus.o_special} !== 7'b1000000) begin
         errs++;
         $display("FAIL flush_after got=%b%b exp=1000000",
                  obs(), bus.o_special);
      end
      tick();
   endtask

   task automatic test_backpressure();
      set_in(1'b1, E203_MULDIV_OP_MUL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int c = 1; c <= 5; c++) begin
         #2;
         checks++;
         if ({obs(), bus.dp_b2b_sel} !== 7'b0000011) begin
            errs++;
            $display("FAIL bp_hold c=%0d got=%b%b exp=0000011",
                     c, obs(), bus.dp_b2b_sel);
         end
         tick();
      end
      bus.o_ready = 1'b1;
      #2;
      checks++;
      if (obs() !== 6'b000001) begin
         errs++;
         $display("FAIL bp_no_reaccept got=%b exp=000001", obs());
      end
      tick();
      #2;
      checks++;
      if ({obs(), bus.dp_b2b_sel} !== 7'b1100000) begin
         errs++;
         $display("FAIL bp_next_accept got=%b%b exp=1100000",
                  obs(), bus.dp_b2b_sel);
      end
      tick();
      bus.i_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_div();
      bit seen;
      set_in(1'b1, E203_MULDIV_OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({obs(), bus.dp_cnt, bus.dp_is_div, bus.o_special}
          !== 14'd0) begin
         errs++;
         $display("FAIL rst_mid got=%b cnt=%0d div=%b exp zero",
                  obs(), bus.dp_cnt, bus.dp_is_div);
      end
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #2;
         if (bus.o_valid) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0 || bus.i_ready !== 1'b1) begin
         errs++;
         $display("FAIL rst_abandon valid_seen=%b rdy=%b exp=0 1",
                  seen, bus.i_ready);
      end
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst_n  = 1'b0;
      set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();
      test_reset();
      test_iterative(E203_MULDIV_OP_MUL, 1'b0, 1'b0);
      test_iterative(E203_MULDIV_OP_DIVU, 1'b0, 1'b0);
      test_iterative(E203_MULDIV_OP_MULHU, 1'b0, 1'b1);
      test_iterative(E203_MULDIV_OP_REMU, 1'b1, 1'b0);
      test_short(E203_MULDIV_OP_DIV, 1'b0, 1'b0, 1'b1, 1'b1);
      test_short(E203_MULDIV_OP_REM, 1'b0, 1'b1, 1'b0, 1'b1);
      test_short(E203_MULDIV_OP_DIVU, 1'b1, 1'b1, 1'b0, 1'b1);
      test_iterative(E203_MULDIV_OP_MULH, 1'b1, 1'b0);
      test_short(E203_MULDIV_OP_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
      test_flush();
      test_backpressure();
      test_reset_mid_div();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
